// File: rtl/demux_seq_pkg.sv
// rtl/demux_seq_pkg.sv - shared constants for the demux sequencer
package demux_seq_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

endpackage

// File: rtl/demux_seq_next_ch.sv
// rtl/demux_seq_next_ch.sv - rotating priority picker: first enabled channel after ptr
module demux_seq_next_ch
  import demux_seq_pkg::*;
(
  input  logic [SEL_W-1:0]  ptr,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  next_ch,
  output logic              found
);

  logic [SEL_W-1:0] idx;

  // Walk the search order backwards so the nearest candidate after ptr is written last;
  // offset NUM_CH wraps to ptr itself, the last choice.
  always_comb begin
    next_ch = ptr;
    found   = 1'b0;
    idx     = ptr;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = ptr + SEL_W'(i);
      if (mask[idx]) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_seq.sv
// rtl/demux_seq.sv - round-robin serial bit sequencer feeding a 1-to-4 demux
module demux_seq
  import demux_seq_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               demux_seq_clk,
  input  logic               demux_seq_reset,
  input  logic               demux_seq_enable,
  input  logic [NUM_CH-1:0]  demux_seq_mask,
  input  logic [DWELL_W-1:0] demux_seq_dwell,
  input  logic               demux_seq_in_data,
  input  logic               demux_seq_in_valid,
  output logic               demux_seq_in_ready,
  output logic               demux_seq_out_data,
  output logic [SEL_W-1:0]   demux_seq_out_select,
  output logic               demux_seq_out_valid,
  output logic               demux_seq_busy
);

  logic [1:0]         state;
  logic [SEL_W-1:0]   ptr;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_eff;
  logic [SEL_W-1:0]   next_ch;
  logic               found;
  logic               xfer;

  demux_seq_next_ch u_next_ch (
    .ptr     (ptr),
    .mask    (demux_seq_mask),
    .next_ch (next_ch),
    .found   (found)
  );

  assign dwell_eff          = (demux_seq_dwell == '0) ? DWELL_W'(1) : demux_seq_dwell;
  assign demux_seq_in_ready = (state == RUN);
  assign demux_seq_busy     = (state != IDLE);
  assign xfer               = demux_seq_in_ready & demux_seq_in_valid;

  always_ff @(posedge demux_seq_clk or posedge demux_seq_reset) begin
    if (demux_seq_reset) begin
      state                <= IDLE;
      ptr                  <= SEL_W'(NUM_CH - 1);
      cnt                  <= '0;
      demux_seq_out_data   <= 1'b0;
      demux_seq_out_select <= '0;
      demux_seq_out_valid  <= 1'b0;
    end else begin
      demux_seq_out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (demux_seq_enable && demux_seq_mask != '0) state <= SCAN;
        end
        SCAN: begin
          if (!demux_seq_enable || !found) begin
            state <= IDLE;
          end else begin
            ptr   <= next_ch;
            cnt   <= dwell_eff;
            state <= RUN;
          end
        end
        RUN: begin
          // enable is deliberately ignored here so a started slot always completes
          if (xfer) begin
            demux_seq_out_data   <= demux_seq_in_data;
            demux_seq_out_select <= ptr;
            demux_seq_out_valid  <= 1'b1;
            cnt                  <= cnt - DWELL_W'(1);
            if (cnt == DWELL_W'(1)) state <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
